obstacle_spawn_scheduler: RTL and testbench

Consumes the 4-bit pseudo-random nibble from the game's LFSR and turns it into obstacle spawn events. It loads a frame interval, counts it down on frame ticks, and then issues a spawn request to the obstacle engine with a req/ack handshake. It sits between the LFSR and the obstacle/sprite logic. It drives the LFSR's advance strobe so that each interval uses a fresh value.

---
 rtl/obstacle_spawn_pkg.sv | 27 ++
 rtl/obstacle_spawn_scheduler_tick_down_counter.sv | 35 +++
 rtl/obstacle_spawn_scheduler.sv | 88 ++++++++
 tb/tb_obstacle_spawn_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/obstacle_spawn_pkg.sv
// obstacle_spawn_pkg
// Shared types and constants for the obstacle spawn scheduler.
//   state_t      : scheduler FSM states
//   CNT_W        : interval counter width
//   LOW_FILL     : constant low nibble of every interval
//   SPAWN_CNT_W  : width of the accepted-spawn statistics counter
//   interval_of  : composes the interval loaded for a given LFSR nibble
package obstacle_spawn_pkg;

    localparam int         CNT_W       = 12;
    localparam int         SPAWN_CNT_W = 8;
    localparam logic [3:0] LOW_FILL    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        REQ   = 2'd3
    } state_t;

    // The random nibble sits above a fixed low fill, so the interval is
    // never below 15 ticks and the countdown can never underflow.
    function automatic logic [CNT_W-1:0] interval_of(input logic [3:0] rand_nib);
        return {{(CNT_W-8){1'b0}}, rand_nib, LOW_FILL};
    endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_tick_down_counter.sv
// tick_down_counter
// Loadable down counter that decrements on qualified ticks.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_value (has priority over tick_en)
//   load_value : value to load
//   tick_en    : qualified tick; decrement by one
//   count      : current count
//   expire     : final tick of the interval (count==1 && tick_en)
module tick_down_counter
    import obstacle_spawn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick_en,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    assign expire = tick_en && (count == CNT_W'(1));

    // NOTE: registers are assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (tick_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler
// Turns the LFSR nibble into timed obstacle spawn requests.
//   clk, reset  : clock and synchronous active-high reset
//   en          : game running; 0 pauses the countdown
//   tick        : one-cycle frame tick
//   rand_nib    : current LFSR output nibble
//   lfsr_step   : one-cycle strobe advancing the LFSR (once per interval)
//   spawn_req   : registered level request, held until spawn_ack
//   spawn_ack   : obstacle engine accepts the request
//   remaining   : ticks left in the current interval
//   spawn_count : accepted spawns, wrapping
module obstacle_spawn_scheduler
    import obstacle_spawn_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   tick,
    input  logic [3:0]             rand_nib,
    output logic                   lfsr_step,
    output logic                   spawn_req,
    input  logic                   spawn_ack,
    output logic [CNT_W-1:0]       remaining,
    output logic [SPAWN_CNT_W-1:0] spawn_count
);

    state_t state;
    state_t state_next;
    logic   cnt_load;
    logic   cnt_tick;
    logic   cnt_expire;

    // Ticks only count in COUNT while enabled; ticks in LOAD or REQ are dropped.
    assign cnt_load = (state == LOAD);
    assign cnt_tick = (state == COUNT) && tick && en;

    // The LFSR advances on the same edge that captures its current nibble,
    // so each interval consumes exactly one fresh value.
    assign lfsr_step = (state == LOAD);

    tick_down_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (interval_of(rand_nib)),
        .tick_en    (cnt_tick),
        .count      (remaining),
        .expire     (cnt_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so every path assigns
    // it and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (en) state_next = LOAD;
            LOAD:    state_next = COUNT;
            COUNT:   if (cnt_expire) state_next = REQ;
            REQ:     if (spawn_ack) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // spawn_req is a flop fed from the next state, so it is high exactly
    // while the FSM sits in REQ and is glitch-free towards the engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            spawn_req   <= 1'b0;
            spawn_count <= '0;
        end else begin
            spawn_req <= (state_next == REQ);
            // Acks outside REQ are ignored; REQ is left on the first ack,
            // so only one ack is ever accepted per request.
            if ((state == REQ) && spawn_ack) begin
                spawn_count <= spawn_count + SPAWN_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
// tb_obstacle_spawn_scheduler
// Self-checking bench: expected interval lengths are queued when an interval
// is loaded and compared against the qualifying-tick count when spawn_req rises.
module tb_obstacle_spawn_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        tick;
    logic [3:0]  rand_nib;
    logic        lfsr_step;
    logic        spawn_req;
    logic        spawn_ack;
    logic [11:0] remaining;
    logic [7:0]  spawn_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_count = 0;
    int sb_q[$];

    obstacle_spawn_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .tick        (tick),
        .rand_nib    (rand_nib),
        .lfsr_step   (lfsr_step),
        .spawn_req   (spawn_req),
        .spawn_ack   (spawn_ack),
        .remaining   (remaining),
        .spawn_count (spawn_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish, expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in LOAD. Runs ticks every 'gap' clocks until
    // spawn_req rises; pause_len ticks with en=0 are inserted once
    // pause_at qualifying ticks have been counted (pause_at<0: no pause).
    task automatic drive_interval(input logic [3:0] nib, input int gap,
                                  input int pause_at, input int pause_len,
                                  input logic tick_in_load);
        int exp_iv;
        int qual;
        int paused;
        bit done;
        exp_iv = int'(nib) * 16 + 15;
        rand_nib = nib;
        tick = tick_in_load;
        check("lfsr_step_in_load", lfsr_step, 1);
        sb_q.push_back(exp_iv);
        cycle();
        tick = 1'b0;
        rand_nib = ~nib;
        check("load_value", remaining, exp_iv);
        check("lfsr_step_once", lfsr_step, 0);
        qual = 0;
        paused = 0;
        done = 0;
        for (int it = 0; it < 1000 && !done; it++) begin
            for (int g = 0; g < gap - 1; g++) cycle();
            en = !((qual == pause_at) && (paused < pause_len));
            tick = 1'b1;
            cycle();
            tick = 1'b0;
            if (en) begin
                qual++;
            end else begin
                paused++;
                if (paused == pause_len)
                    check("pause_hold", remaining, exp_iv - pause_at);
            end
            en = 1'b1;
            if (spawn_req) begin
                check("spawn_ticks", qual, sb_q.pop_front());
                check("remaining_zero_at_req", remaining, 0);
                done = 1;
            end
        end
        if (!done) begin
            check("spawn_timeout", 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    // Entered with spawn_req high. Holds off the ack for 'hold' cycles with
    // ticks running, then gives a single-cycle ack (optionally with a tick).
    task automatic do_ack(input int hold, input logic tick_with_ack);
        for (int i = 0; i < hold; i++) begin
            tick = (i % 4 == 3);
            cycle();
            check("req_held", spawn_req, 1);
            check("remaining_held", remaining, 0);
            check("no_step_in_req", lfsr_step, 0);
        end
        spawn_ack = 1'b1;
        tick = tick_with_ack;
        cycle();
        spawn_ack = 1'b0;
        tick = 1'b0;
        exp_count = (exp_count + 1) % 256;
        check("req_dropped", spawn_req, 0);
        check("spawn_count", spawn_count, exp_count);
        check("load_after_ack", lfsr_step, 1);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b0;
        tick = 1'b0;
        rand_nib = 4'h0;
        spawn_ack = 1'b0;
        cycle();
        cycle();
        check("rst_req", spawn_req, 0);
        check("rst_step", lfsr_step, 0);
        check("rst_remaining", remaining, 0);
        check("rst_count", spawn_count, 0);
        reset = 1'b0;
        cycle();
        cycle();
        check("idle_no_step", lfsr_step, 0);
        en = 1'b1;
        cycle();

        // Minimum interval, immediate ack.
        drive_interval(4'h0, 4, -1, 0, 1'b0);
        do_ack(0, 1'b0);

        // Maximum interval, then backpressure for 20 cycles.
        drive_interval(4'hF, 4, -1, 0, 1'b0);
        do_ack(20, 1'b0);

        // Pause after 10 ticks for 30 ticks.
        drive_interval(4'h3, 4, 10, 30, 1'b0);
        do_ack(2, 1'b1);

        // Collision: tick with the ack above, tick in the LOAD cycle here.
        drive_interval(4'h1, 2, -1, 0, 1'b1);

        // Reset while a request is pending.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        en = 1'b0;
        exp_count = 0;
        check("midrst_req", spawn_req, 0);
        check("midrst_remaining", remaining, 0);
        check("midrst_count", spawn_count, 0);
        check("midrst_step", lfsr_step, 0);
        spawn_ack = 1'b1;
        cycle();
        spawn_ack = 1'b0;
        check("spurious_ack_count", spawn_count, 0);
        check("spurious_ack_req", spawn_req, 0);
        check("idle_after_rst", lfsr_step, 0);
        en = 1'b1;
        cycle();

        // 256 spawns: the counter wraps back to zero.
        for (int i = 0; i < 256; i++) begin
            drive_interval(4'(i % 3), 1, -1, 0, 1'b0);
            do_ack(i % 2, 1'b0);
        end
        check("wrap_to_zero", spawn_count, 0);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
